icache_fetch: RTL

- Direct-mapped, read-only instruction cache directly downstream of the PC register.
- Consumes the current `Pc` and returns the instruction word together with `hit`.
- The PC register advances only while `hit` is 1; a miss therefore stalls fetch while the block refills the line from instruction memory over a ready-qualified request handshake.
- All state updates on the rising edge of `clk`. `hit` and `instruction` are combinational from `pc` and the arrays, so they are stable at the PC register's falling-edge sample point.

---
 rtl/icache_fetch.sv | 66 ++++++
 1 files changed

// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped read-only instruction cache with a stalling line refill
module icache_fetch #(
  parameter int OFFSET_BITS = 2,
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        hit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  localparam int TAG_BITS = 32 - 2 - OFFSET_BITS - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_n;
  logic [LINES-1:0] valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0] data [LINES][WORDS];
  logic [TAG_BITS+INDEX_BITS-1:0] line;
  logic [OFFSET_BITS-1:0] fill_cnt;
  logic [OFFSET_BITS-1:0] offset;
  logic [INDEX_BITS-1:0] index, idx;
  logic [TAG_BITS-1:0] tag;
  logic lookup, last, unused_pc;
  assign offset = pc[OFFSET_BITS+1:2];
  assign index = pc[OFFSET_BITS+INDEX_BITS+1:OFFSET_BITS+2];
  assign tag = pc[31:OFFSET_BITS+INDEX_BITS+2];
  assign unused_pc = ^pc[1:0];
  assign idx = line[INDEX_BITS-1:0];
  assign last = fill_cnt == OFFSET_BITS'(WORDS - 1);
  assign lookup = valid[index] && tags[index] == tag;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    hit = state == IDLE && lookup;
    mem_req = state == FILL;
    state_n = state == IDLE ? (lookup ? IDLE : FILL) : (mem_ready && last ? IDLE : FILL);
    instruction = hit ? data[index][offset] : '0;
    mem_addr = mem_req ? {line, fill_cnt, 2'b00} : '0;
  end
  // The line is invalidated on fill entry, so a partial refill can never hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      fill_cnt <= '0;
      line <= '0;
    end else if (state == IDLE && !lookup) begin
      line <= pc[31:OFFSET_BITS+2];
      valid[index] <= 1'b0;
      fill_cnt <= '0;
    end else if (state == FILL && mem_ready) begin
      fill_cnt <= fill_cnt + 1'b1;
      if (last) valid[idx] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && state == FILL && mem_ready) begin
      data[idx][fill_cnt] <= mem_rdata;
      if (last) tags[idx] <= line[TAG_BITS+INDEX_BITS-1:INDEX_BITS];
    end
  end
endmodule
